// File: rtl/fsm_run_pkg.sv
// fsm_run_pkg: shared types for the FSM run sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
//   state_t  - sequencer phase (IDLE, RESET, RUN, DONE)
//   result_t - per-cycle run verdict (NONE, HIT, TIMEOUT)
package fsm_run_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    HIT     = 2'd1,
    TIMEOUT = 2'd2
  } result_t;

endpackage

// File: rtl/seq_cycle_counter.sv
// seq_cycle_counter: saturating W-bit counter with clear, enable and terminal compare.
// Latency: count updates one clock after en/clr; at_term is combinational.
// Backpressure: none; counts every enabled cycle and sticks at all-ones.
//   clk, rst - clock, async active-high reset
//   clr      - synchronous clear (wins over en)
//   en       - count enable
//   term     - terminal value
//   count    - registered count
//   at_term  - the value count takes on this edge (if not cleared) equals term
module seq_cycle_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         at_term
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] nxt;

  always_comb begin
    nxt = count;
    if (en && (count != '1)) begin
      nxt = count + ONE;
    end
  end

  // Compare against the post-increment value so the caller can act on the
  // same edge the terminal count is reached.
  assign at_term = (nxt == term);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      count <= nxt;
    end
  end

endmodule

// File: rtl/fsm_run_sequencer.sv
// fsm_run_sequencer: holds a DUT FSM in reset, releases it and steps it for a bounded run,
// scoring target reachability, the reset invariant and the set of visited states.
// Latency: start to first dut_en is RST_CYCLES+1 clocks; start is ignored while busy or in DONE.
//   clk, rst         - clock, async active-high reset
//   start            - begin a run (only honoured in IDLE)
//   target_state     - state to reach; max_cycles - RUN budget (both latched at start)
//   dut_state        - observed DUT state
//   dut_rst, dut_en  - DUT reset and step enable
//   busy, done       - run in progress / one-cycle end-of-run pulse
//   hit, timeout     - run verdict, held until next start
//   reset_violation  - DUT left RESET_STATE while held in reset
//   visited          - bitmap of states seen during RUN
//   cycles_used      - RUN cycles consumed
module fsm_run_sequencer
  import fsm_run_pkg::*;
#(
  parameter int SW          = 2,
  parameter int CW          = 8,
  parameter int RST_CYCLES  = 1,
  parameter int RESET_STATE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SW-1:0]     target_state,
  input  logic [CW-1:0]     max_cycles,
  input  logic [SW-1:0]     dut_state,
  output logic              dut_rst,
  output logic              dut_en,
  output logic              busy,
  output logic              done,
  output logic              hit,
  output logic              timeout,
  output logic              reset_violation,
  output logic [2**SW-1:0]  visited,
  output logic [CW-1:0]     cycles_used
);

  localparam logic [SW-1:0] RST_ST  = SW'(RESET_STATE);
  localparam logic [3:0]    RST_LEN = 4'(RST_CYCLES);

  state_t        state;
  logic [SW-1:0] tgt;
  logic [CW-1:0] max_lat;
  result_t       res;

  logic          launch;
  logic          rc_term;
  logic [3:0]    rc_count;
  logic          cc_term;

  assign launch = (state == IDLE) && start;

  // Reset-hold length counter; only its terminal flag is consumed.
  seq_cycle_counter #(.W(4)) u_rst_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (launch),
    .en      (state == RESET),
    .term    (RST_LEN),
    .count   (rc_count),
    .at_term (rc_term)
  );

  logic unused_rst_cnt;
  assign unused_rst_cnt = ^rc_count;

  // RUN budget counter; its register is the cycles_used output, so it
  // freezes naturally once the FSM leaves RUN.
  seq_cycle_counter #(.W(CW)) u_cyc_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (launch),
    .en      (state == RUN),
    .term    (max_lat),
    .count   (cycles_used),
    .at_term (cc_term)
  );

  // Verdict for the current RUN cycle. A hit takes precedence over the last
  // budget cycle. A zero budget never matches the post-increment count, so
  // it is terminated explicitly after one cycle.
  always_comb begin
    res = NONE;
    if (dut_state == tgt) begin
      res = HIT;
    end else if (cc_term || (max_lat == '0)) begin
      res = TIMEOUT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      dut_rst         <= 1'b1;
      dut_en          <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      hit             <= 1'b0;
      timeout         <= 1'b0;
      reset_violation <= 1'b0;
      visited         <= '0;
      tgt             <= '0;
      max_lat         <= '0;
    end else begin
      case (state)
        IDLE: begin
          dut_rst <= 1'b1;
          dut_en  <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          if (start) begin
            tgt             <= target_state;
            max_lat         <= max_cycles;
            hit             <= 1'b0;
            timeout         <= 1'b0;
            reset_violation <= 1'b0;
            visited         <= '0;
            busy            <= 1'b1;
            state           <= RESET;
          end
        end
        RESET: begin
          if (dut_state != RST_ST) begin
            reset_violation <= 1'b1;
          end
          if (rc_term) begin
            dut_rst <= 1'b0;
            dut_en  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          visited[dut_state] <= 1'b1;
          if (res != NONE) begin
            hit     <= (res == HIT);
            timeout <= (res == TIMEOUT);
            done    <= 1'b1;
            dut_en  <= 1'b0;
            dut_rst <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_run_sequencer.sv
// tb_fsm_run_sequencer: directed bench for fsm_run_sequencer with a counting DUT model.
// The model walks 0,1,2,3 while enabled, can be held stuck, and can show state 2 while in reset.
module tb_fsm_run_sequencer;

  localparam int SW   = 2;
  localparam int CW   = 8;
  localparam int RSTC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [SW-1:0] target_state;
  logic [CW-1:0] max_cycles;
  logic [SW-1:0] dut_state;
  logic          dut_rst, dut_en, busy, done, hit, timeout, reset_violation;
  logic [3:0]    visited;
  logic [CW-1:0] cycles_used;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fsm_run_sequencer #(
    .SW(SW), .CW(CW), .RST_CYCLES(RSTC), .RESET_STATE(0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .target_state    (target_state),
    .max_cycles      (max_cycles),
    .dut_state       (dut_state),
    .dut_rst         (dut_rst),
    .dut_en          (dut_en),
    .busy            (busy),
    .done            (done),
    .hit             (hit),
    .timeout         (timeout),
    .reset_violation (reset_violation),
    .visited         (visited),
    .cycles_used     (cycles_used)
  );

  // Small FSM under test
  logic [SW-1:0] model_q;
  logic          stuck, inject;

  always_ff @(posedge clk) begin
    if (dut_rst)              model_q <= '0;
    else if (dut_en && !stuck) model_q <= model_q + 2'd1;
  end
  assign dut_state = (inject && dut_rst) ? 2'd2 : model_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic [1:0] tgt;
    logic [7:0] maxc;
    logic       stk;
    logic       inj;
    logic       e_hit;
    logic       e_to;
    logic       e_viol;
    logic [7:0] e_cyc;
    logic [3:0] e_vis;
  } vec_t;

  vec_t vecs[7];

  task automatic wait_en(output int lat);
    lat = 1;
    while (!dut_en && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat, n, pulses;
    @(negedge clk);
    stuck = v.stk; inject = v.inj;
    target_state = v.tgt; max_cycles = v.maxc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({v.name, "_start_busy"}, busy, 1);
    check({v.name, "_start_clr"}, {hit, timeout, reset_violation, visited}, 0);
    wait_en(lat);
    check({v.name, "_latency"}, lat, RSTC + 1);
    inject = 1'b0;
    wait_done(n);
    check({v.name, "_done"}, done, 1);
    check({v.name, "_hit"}, hit, v.e_hit);
    check({v.name, "_timeout"}, timeout, v.e_to);
    check({v.name, "_viol"}, reset_violation, v.e_viol);
    check({v.name, "_cycles"}, cycles_used, v.e_cyc);
    check({v.name, "_visited"}, visited, v.e_vis);
    check({v.name, "_done_dut"}, {dut_rst, dut_en}, 2'b10);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check({v.name, "_after_busy"}, busy, 0);
    check({v.name, "_extra_done"}, pulses, 0);
    check({v.name, "_held"}, {hit, timeout, reset_violation}, {v.e_hit, v.e_to, v.e_viol});
  endtask

  initial begin
    int lat, n, pulses;
    //          name      tgt max stk inj hit to viol cyc  vis
    vecs[0] = '{"reach",  3, 10, 0, 0, 1, 0, 0, 4, 4'b1111};
    vecs[1] = '{"unreach",3,  5, 1, 0, 0, 1, 0, 5, 4'b0001};
    vecs[2] = '{"rsttgt", 0,  0, 0, 0, 1, 0, 0, 1, 4'b0001};
    vecs[3] = '{"rstviol",3, 10, 0, 1, 1, 0, 1, 4, 4'b1111};
    vecs[4] = '{"bound",  3,  4, 0, 0, 1, 0, 0, 4, 4'b1111};
    vecs[5] = '{"budget2",2,  2, 0, 0, 0, 1, 0, 2, 4'b0011};
    vecs[6] = '{"zeromiss",1, 0, 0, 0, 0, 1, 0, 1, 4'b0001};

    rst = 1'b1; start = 1'b0; target_state = '0; max_cycles = '0;
    stuck = 1'b0; inject = 1'b0;
    @(negedge clk); @(negedge clk);
    check("reset_ctl", {dut_rst, dut_en, busy, done}, 4'b1000);
    check("reset_res", {hit, timeout, reset_violation}, 0);
    check("reset_vis", visited, 0);
    check("reset_cyc", cycles_used, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // start during RUN is ignored; start on the DONE cycle is ignored
    @(negedge clk);
    target_state = 2'd3; max_cycles = 8'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_en(lat);
    @(negedge clk);
    target_state = 2'd0; max_cycles = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("restart_done", done, 1);
    check("restart_hit", {hit, timeout}, 2'b10);
    check("restart_cyc", cycles_used, 4);
    check("restart_vis", visited, 4'b1111);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("donestart_busy", busy, 0);
    @(negedge clk);
    check("donestart_idle", {busy, dut_rst, hit}, 3'b011);

    // rst mid-RUN: asynchronous return to reset values, no done pulse
    @(negedge clk);
    target_state = 2'd3; max_cycles = 8'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_en(lat);
    @(negedge clk); @(negedge clk);
    check("prerst_cyc", cycles_used, 2);
    rst = 1'b1;
    #1;
    check("midrst_ctl", {dut_rst, dut_en, busy, done}, 4'b1000);
    check("midrst_vis", visited, 0);
    check("midrst_cyc", cycles_used, 0);
    check("midrst_res", {hit, timeout, reset_violation}, 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    check("midrst_quiet", pulses, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fsm_run_sequencer.md
Name: fsm_run_sequencer

Overview:
Sequencer that drives one small state-machine DUT through a bounded run. It holds the DUT in reset, releases it, and steps it for at most a configured number of cycles. While stepping it monitors the DUT state for a target value (a reachability/cover check), checks the reset invariant, and records a visited-state bitmap. It is the on-chip counterpart of the platform's formal reachability harnesses, used to sequence and score FSM blocks in simulation and emulation.

Parameters:
SW, 2, DUT state width in bits
CW, 8, cycle-counter width; max run length is 2**CW-1
RST_CYCLES, 1, number of cycles dut_rst is held asserted (1..15)
RESET_STATE, 0, state value the DUT must show while in reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle pulse; begins a run when idle
target_state  in  SW  state whose reachability is checked; sampled at start
max_cycles  in  CW  step budget after reset release; sampled at start; 0 is legal
dut_state  in  SW  observed DUT state
dut_rst  out  1  reset to the DUT
dut_en  out  1  step enable to the DUT
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse at end of run
hit  out  1  target reached in this run; held until next start
timeout  out  1  budget exhausted without hit; held until next start
reset_violation  out  1  dut_state != RESET_STATE observed while dut_rst is high; sticky until next start
visited  out  2**SW  bit i set if dut_state==i was seen during RUN; cleared at start
cycles_used  out  CW  RUN cycles consumed; frozen at end of run

Behaviour:
- Reset (async, rst=1): state=IDLE; dut_rst=1; dut_en=0; busy=0; done=0; hit=0; timeout=0; reset_violation=0; visited=0; cycles_used=0; internal counters=0.
- Clock and reset are named clk and rst; reset is asynchronous, active-high.
- States: IDLE, RESET, RUN, DONE. All outputs are registered.
- IDLE: dut_rst=1, dut_en=0. When start=1: latch target_state and max_cycles; clear hit, timeout, reset_violation, visited and cycles_used; go to RESET with rst_cnt=0.
- RESET: dut_rst=1, busy=1. Each cycle compare dut_state with RESET_STATE; on mismatch set reset_violation. After RST_CYCLES cycles in RESET, go to RUN. dut_rst is 0 from the first RUN cycle.
- RUN: dut_rst=0, dut_en=1, busy=1. Each cycle:
  - set visited[dut_state];
  - increment cycles_used, saturating at max.
  - If dut_state==target, set hit and go to DONE. The hit check applies on the first RUN cycle, so a reset-state target hits with cycles_used=1.
  - Otherwise, when cycles_used (after increment) == latched max_cycles, set timeout and go to DONE.
  - If hit and the last budget cycle coincide, hit wins and timeout stays 0.
- max_cycles=0: RUN lasts exactly one cycle. It ends with a hit if the target matches on that cycle, otherwise with timeout.
- DONE: one cycle. done=1, dut_en=0, dut_rst=1 (DUT re-held), busy=0 on the following cycle. Then go to IDLE.
- start while busy or in DONE is ignored; it has no effect on latched values.
- hit and timeout are mutually exclusive; exactly one of them is set at every done pulse.
- rst asserted mid-run: immediate return to IDLE with all reset values. No done pulse is produced.
- Latency: start to first dut_en cycle is RST_CYCLES+1 clocks.

Decomposition:
- Package fsm_run_pkg: state enum (IDLE, RESET, RUN, DONE) and a result-code typedef (NONE, HIT, TIMEOUT).
- Sub-module seq_cycle_counter: saturating CW-bit counter with clear and enable and a terminal-count compare. It is reused for rst_cnt and cycles_used.

Test Plan:
- Reachable target: DUT walks states 0→1→2→3; target=3, max=10 → hit=1, timeout=0, cycles_used=4, visited=4'b1111, one done pulse.
- Unreachable target: DUT stuck at 0; target=3, max=5 → timeout=1, hit=0, cycles_used=5, visited=4'b0001.
- Reset-state target: target=0, max=0 → hit=1 on the first RUN cycle, cycles_used=1, timeout=0.
- Reset invariant failure: DUT shows state 2 while dut_rst=1, RST_CYCLES=2 → reset_violation=1, held through done; cleared by the next start.
- Budget boundary: target first reached exactly on cycle max=4 → hit=1, timeout=0.
- Robustness:
  - start pulsed during RUN → no restart; latched target unchanged.
  - rst pulsed mid-RUN → outputs return to reset values on the same edge; no done pulse.
